// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

  localparam int          XLEN    = 32;
  localparam int          ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // One decoded-ready fetch entry: the instruction word and the PC it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits from a redirect are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for in-flight PCs and the fetch queue.
// Latency: a push is visible at pop_data on the next cycle (no bypass).
// Backpressure: none internally; caller must not push when full or pop when empty.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     write one entry
//   pop                 drop the head entry
//   flush               discard all entries (wins over push/pop)
//   pop_data            head entry (undefined when empty)
//   count, full, empty  occupancy
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  // Guards keep pointers coherent even if a caller misbehaves.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads, pairs words with PCs for decode.
// Latency: memory response in cycle N appears on if_* in cycle N+1 (no bypass).
// Backpressure: requests gated by credit (outstanding + queued < FQ_DEPTH); if_* held while !if_ready.
//
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   imem_req_valid/ready, imem_req_addr         word read request to instruction memory
//   imem_rsp_valid, imem_rsp_data               in-order read responses (no backpressure)
//   redirect_valid, redirect_pc                 next-PC override; flushes queued/in-flight work
//   if_valid/ready, if_instr, if_pc             {instr, pc} to decode
module instr_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int          CW     = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] FQ_LIM = (CW + 1)'(FQ_DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] out_q;    // requests accepted but not yet answered
  logic [CW-1:0] drop_q;   // responses still owed to a superseded PC stream

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          accept;
  logic          rsp_keep;

  logic [31:0]   inf_pc;
  logic [CW-1:0] inf_count;
  logic          inf_full;
  logic          inf_empty;

  fetch_entry_t  fq_in;
  fetch_entry_t  fq_head;
  logic [CW-1:0] fq_count;
  logic          fq_full;
  logic          fq_empty;
  logic          fq_pop;

  // Every accepted request reserves a queue slot, so the queue can never overflow
  // and responses need no backpressure.
  assign in_use    = {1'b0, out_q} + {1'b0, fq_count};
  assign credit_ok = (in_use < FQ_LIM);

  // Gated by rst_n so the request line drops the moment reset asserts.
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response arriving during a redirect belongs to the old stream.
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign fq_in  = '{instr: imem_rsp_data, pc: inf_pc};
  assign fq_pop = if_valid && if_ready;

  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN)) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .pop_data  (inf_pc),
    .count     (inf_count),
    .full      (inf_full),
    .empty     (inf_empty)
  );

  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fetchq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (fq_in),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .pop_data  (fq_head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign if_valid = !fq_empty;
  assign if_instr = fq_empty ? '0 : fq_head.instr;
  assign if_pc    = fq_empty ? '0 : fq_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      if (redirect_valid)  pc_q <= align_pc(redirect_pc);
      else if (accept)     pc_q <= pc_q + PC_STEP;

      case ({accept, imem_rsp_valid})
        2'b10:   out_q <= out_q + CW'(1);
        2'b01:   out_q <= out_q - CW'(1);
        default: ;
      endcase

      // On redirect every response not yet returned is stale; the one
      // arriving this cycle is already discarded via rsp_keep.
      if (redirect_valid)
        drop_q <= imem_rsp_valid ? (out_q - CW'(1)) : out_q;
      else if (imem_rsp_valid && (drop_q != '0))
        drop_q <= drop_q - CW'(1);
    end
  end

  a_inf_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !inf_empty);
  a_inf_push_nonfull: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> !inf_full);
  a_inf_tracks_out: assert property (@(posedge clk) disable iff (!rst_n)
    inf_count == out_q);
  a_fq_push_nonfull: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !fq_full);
  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= out_q);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency in-order memory model.
// Latency: cycle = negedge to negedge; inputs set at negedge, outputs sampled 1 time unit later.
// Backpressure: memory always ready; if_ready driven per test.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc;
  int          lat;
  int          n_hs;
  int          n_acc;
  logic [31:0] exp_pc;
  logic [31:0] addr_q[$];
  int          due_q[$];

  logic        s_rv;
  logic [31:0] s_ra;
  logic        s_iv;
  logic [31:0] s_ii;
  logic [31:0] s_ip;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample();
    s_rv = imem_req_valid;
    s_ra = imem_req_addr;
    s_iv = if_valid;
    s_ii = if_instr;
    s_ip = if_pc;
  endtask

  // Present this cycle's memory response, then sample the settled outputs.
  task automatic drive_sample();
    if (rst_n && due_q.size() > 0 && due_q[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(addr_q[0]);
      void'(addr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1 sample();
  endtask

  // Record what the coming rising edge will commit, score delivered entries.
  task automatic advance();
    if (s_rv && imem_req_ready) begin
      addr_q.push_back(s_ra);
      due_q.push_back(cyc + lat);
      n_acc++;
    end
    if (s_iv && if_ready) begin
      chk("if_pc", s_ip, exp_pc);
      chk("if_instr", s_ii, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_hs++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_sample();
      advance();
    end
  endtask

  // Called at a negedge; releases reset at a negedge so cycle 0 follows.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    addr_q.delete();
    due_q.delete();
    drive_sample();
    chk("rst_req_vld", s_rv, 0);
    chk("rst_if_vld", s_iv, 0);
    chk("rst_if_instr", s_ii, 0);
    chk("rst_if_pc", s_ip, 0);
    advance();
    drive_sample();
    advance();
    rst_n  = 1'b1;
    cyc    = 0;
    exp_pc = 32'h0;
    n_hs   = 0;
    n_acc  = 0;
  endtask

  // Assert reset in the middle of a cycle (after drive_sample) and check outputs drop at once.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 sample();
    chk("mr_req_vld", s_rv, 0);
    chk("mr_if_vld", s_iv, 0);
    chk("mr_if_pc", s_ip, 0);
    chk("mr_if_instr", s_ii, 0);
    addr_q.delete();
    due_q.delete();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    do_reset();
  endtask

  initial begin
    bit got;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    cyc = 0; lat = 1; n_hs = 0; n_acc = 0; exp_pc = 32'h0;
    @(negedge clk);

    // Streaming from reset with single-cycle memory.
    do_reset();
    lat = 1; if_ready = 1'b1;
    drive_sample();
    chk("t1_req_vld0", s_rv, 1);
    chk("t1_req_addr0", s_ra, 32'h0);
    chk("t1_if_vld0", s_iv, 0);
    advance();
    drive_sample();
    chk("t1_req_addr1", s_ra, 32'h4);
    chk("t1_if_vld1", s_iv, 0);
    advance();
    drive_sample();
    chk("t1_if_vld2", s_iv, 1);
    chk("t1_if_pc2", s_ip, 32'h0);
    advance();
    run(12);
    chk("t1_hs_count", n_hs >= 8, 1);

    // Decode stalled for 5 cycles after the first entry shows up.
    do_reset();
    lat = 1; if_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_sample();
      if (i >= 2) begin
        chk("t2_hold_vld", s_iv, 1);
        chk("t2_hold_pc", s_ip, 32'h0);
        chk("t2_hold_instr", s_ii, mem_word(32'h0));
      end
      advance();
    end
    chk("t2_acc_count", n_acc, 2);
    if_ready = 1'b1;
    run(10);
    chk("t2_hs_count", n_hs >= 5, 1);

    // Redirect with two requests outstanding to slow memory.
    do_reset();
    lat = 3; if_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0101;
    drive_sample();
    chk("t3_req_vld_R", s_rv, 0);
    advance();
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0100;
    drive_sample();
    chk("t3_if_vld_R1", s_iv, 0);
    advance();
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_sample();
      if (!got && s_rv) begin
        got = 1'b1;
        chk("t3_new_addr", s_ra, 32'h0000_0100);
      end
      advance();
    end
    chk("t3_new_req_seen", got, 1);
    run(10);
    chk("t3_hs_count", n_hs >= 3, 1);

    // Redirect in the same cycle as a response and an if handshake.
    do_reset();
    lat = 1; if_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    drive_sample();
    chk("t4_head_vld_R", s_iv, 1);
    chk("t4_head_pc_R", s_ip, 32'h0);
    advance();
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0200;
    drive_sample();
    chk("t4_if_vld_R1", s_iv, 0);
    chk("t4_req_vld_R1", s_rv, 1);
    chk("t4_req_addr_R1", s_ra, 32'h0000_0200);
    advance();
    run(8);
    chk("t4_hs_count", n_hs >= 4, 1);

    // PC wrap at the top of the address space; low redirect bits ignored.
    do_reset();
    lat = 1; if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    drive_sample();
    advance();
    redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    drive_sample();
    chk("t5_addr_top", s_ra, 32'hFFFF_FFFC);
    advance();
    drive_sample();
    chk("t5_req_vld_wrap", s_rv, 1);
    chk("t5_addr_wrap", s_ra, 32'h0000_0000);
    advance();
    run(6);
    chk("t5_hs_count", n_hs >= 3, 1);

    // Reset with two requests outstanding, then with traffic on both sides.
    do_reset();
    lat = 3; if_ready = 1'b1;
    run(2);
    drive_sample();
    chk("t6_credit_stall", s_rv, 0);
    mid_reset();
    lat = 1;
    drive_sample();
    chk("t6_first_vld", s_rv, 1);
    chk("t6_first_addr", s_ra, 32'h0);
    advance();
    run(8);
    chk("t6_hs_count", n_hs >= 4, 1);

    lat = 3;
    do_reset();
    run(5);
    drive_sample();
    chk("t6b_req_vld_pre", s_rv, 1);
    chk("t6b_if_vld_pre", s_iv, 1);
    chk("t6b_if_pc_pre", s_ip, 32'h4);
    mid_reset();
    lat = 1;
    drive_sample();
    chk("t6b_first_addr", s_ra, 32'h0);
    advance();
    run(6);
    chk("t6b_hs_count", n_hs >= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
